// File: rtl/mirfak_clint_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mirfak_clint_pkg : register offsets, reset values, decode helpers    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package mirfak_clint_pkg;

    localparam logic [15:0] CLINT_MSIP        = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
    localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        REG_NONE    = 3'd0,
        REG_MSIP    = 3'd1,
        REG_CMP_LO  = 3'd2,
        REG_CMP_HI  = 3'd3,
        REG_TIME_LO = 3'd4,
        REG_TIME_HI = 3'd5
    } clint_reg_e;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_val,
        input logic [31:0] wdat,
        input logic [3:0]  sel
    );
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                res[8*b +: 8] = wdat[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mirfak_clint_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mirfak_clint_timer : prescaler, mtime/mtimecmp and mtip comparator   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module mirfak_clint_timer
    import mirfak_clint_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wr_time_lo_i,
    input  logic        wr_time_hi_i,
    input  logic        wr_cmp_lo_i,
    input  logic        wr_cmp_hi_i,
    input  logic [31:0] wdat_i,
    input  logic [3:0]  wsel_i,
    output logic [63:0] mtime_o,
    output logic [63:0] mtimecmp_o,
    output logic        mtip_o
);

    localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);

    logic [15:0] presc_q, presc_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] cmp_q, cmp_d;
    logic        mtip_q, mtip_d;
    logic        tick;

    always_comb begin
        tick    = (presc_q == DIV_LAST);
        presc_d = tick ? 16'd0 : presc_q + 16'd1;

        // A bus write to either half wins over the tick; the untouched half holds.
        mtime_d = mtime_q;
        if (wr_time_lo_i || wr_time_hi_i) begin
            if (wr_time_lo_i) begin
                mtime_d[31:0] = byte_merge(mtime_q[31:0], wdat_i, wsel_i);
            end
            if (wr_time_hi_i) begin
                mtime_d[63:32] = byte_merge(mtime_q[63:32], wdat_i, wsel_i);
            end
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end

        cmp_d = cmp_q;
        if (wr_cmp_lo_i) begin
            cmp_d[31:0] = byte_merge(cmp_q[31:0], wdat_i, wsel_i);
        end
        if (wr_cmp_hi_i) begin
            cmp_d[63:32] = byte_merge(cmp_q[63:32], wdat_i, wsel_i);
        end

        mtip_d = (mtime_q >= cmp_q);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            presc_q <= 16'd0;
            mtime_q <= 64'd0;
            cmp_q   <= MTIMECMP_RST;
            mtip_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            mtime_q <= mtime_d;
            cmp_q   <= cmp_d;
            mtip_q  <= mtip_d;
        end
    end

    assign mtime_o    = mtime_q;
    assign mtimecmp_o = cmp_q;
    assign mtip_o     = mtip_q;

endmodule
`default_nettype wire

// File: rtl/mirfak_clint.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mirfak_clint : Wishbone classic CLINT (mtime, mtimecmp, msip)        |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module mirfak_clint
    import mirfak_clint_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] wbs_addr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic        xint_mtip_o,
    output logic        xint_msip_o
);

    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic        msip_q, msip_d;
    logic [31:0] dat_q, dat_d;
    logic [15:0] offset;
    logic        req;
    logic        wr;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        unused_addr;
    clint_reg_e  reg_sel;

    assign offset      = {wbs_addr_i[15:2], 2'b00};
    assign unused_addr = ^wbs_addr_i[1:0];
    // The outstanding response itself blocks a new request, so a held stb acks every other cycle.
    assign req         = wbs_cyc_i & wbs_stb_i & ~ack_q & ~err_q;
    // sel == 0 is acked but writes nothing, so it also leaves the mtime tick alone.
    assign wr          = req & wbs_we_i & (|wbs_sel_i);

    always_comb begin
        reg_sel = REG_NONE;
        if (wbs_addr_i[31:16] == BASE_ADDR[31:16]) begin
            case (offset)
                CLINT_MSIP:        reg_sel = REG_MSIP;
                CLINT_MTIMECMP_LO: reg_sel = REG_CMP_LO;
                CLINT_MTIMECMP_HI: reg_sel = REG_CMP_HI;
                CLINT_MTIME_LO:    reg_sel = REG_TIME_LO;
                CLINT_MTIME_HI:    reg_sel = REG_TIME_HI;
                default:           reg_sel = REG_NONE;
            endcase
        end
    end

    always_comb begin
        ack_d  = req & (reg_sel != REG_NONE);
        err_d  = req & (reg_sel == REG_NONE);
        dat_d  = 32'd0;
        msip_d = msip_q;
        if (ack_d && !wbs_we_i) begin
            case (reg_sel)
                REG_MSIP:    dat_d = {31'd0, msip_q};
                REG_CMP_LO:  dat_d = mtimecmp[31:0];
                REG_CMP_HI:  dat_d = mtimecmp[63:32];
                REG_TIME_LO: dat_d = mtime[31:0];
                REG_TIME_HI: dat_d = mtime[63:32];
                default:     dat_d = 32'd0;
            endcase
        end
        if (wr && (reg_sel == REG_MSIP) && wbs_sel_i[0]) begin
            msip_d = wbs_dat_i[0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            msip_q <= 1'b0;
            dat_q  <= 32'd0;
        end else begin
            ack_q  <= ack_d;
            err_q  <= err_d;
            msip_q <= msip_d;
            dat_q  <= dat_d;
        end
    end

    mirfak_clint_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .wr_time_lo_i (wr && (reg_sel == REG_TIME_LO)),
        .wr_time_hi_i (wr && (reg_sel == REG_TIME_HI)),
        .wr_cmp_lo_i  (wr && (reg_sel == REG_CMP_LO)),
        .wr_cmp_hi_i  (wr && (reg_sel == REG_CMP_HI)),
        .wdat_i       (wbs_dat_i),
        .wsel_i       (wbs_sel_i),
        .mtime_o      (mtime),
        .mtimecmp_o   (mtimecmp),
        .mtip_o       (xint_mtip_o)
    );

    assign wbs_ack_o   = ack_q;
    assign wbs_err_o   = err_q;
    assign wbs_dat_o   = dat_q;
    assign xint_msip_o = msip_q;

endmodule
`default_nettype wire

// File: tb/tb_mirfak_clint.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mirfak_clint : randomized bus traffic against a behavioural CLINT |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_mirfak_clint;

    localparam int TICK = 1;
    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clk   = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] addr  = 32'd0;
    logic [31:0] wdat  = 32'd0;
    logic [3:0]  sel   = 4'd0;
    logic        cyc   = 1'b0;
    logic        stb   = 1'b0;
    logic        we    = 1'b0;
    logic [31:0] dat_o;
    logic        ack_o, err_o, mtip_o, msip_o;

    always #5 clk = ~clk;

    mirfak_clint #(
        .BASE_ADDR (BASE),
        .TICK_DIV  (TICK)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .wbs_addr_i  (addr),
        .wbs_dat_i   (wdat),
        .wbs_sel_i   (sel),
        .wbs_cyc_i   (cyc),
        .wbs_stb_i   (stb),
        .wbs_we_i    (we),
        .wbs_dat_o   (dat_o),
        .wbs_ack_o   (ack_o),
        .wbs_err_o   (err_o),
        .xint_mtip_o (mtip_o),
        .xint_msip_o (msip_o)
    );

    // Behavioural state of the interruptor.
    logic [63:0] m_time, m_cmp;
    logic        m_msip, m_mtip, m_ack, m_err;
    logic [31:0] m_dat;
    bit          m_dat_chk;
    int          m_presc;

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        if (a[31:16] != 16'h0200) return -1;
        case ({a[15:2], 2'b00})
            16'h0000: return 0;
            16'h4000: return 1;
            16'h4004: return 2;
            16'hBFF8: return 3;
            16'hBFFC: return 4;
            default:  return -1;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic model_step();
        logic [63:0] nt, nc;
        bit          req, twr, tick;
        int          r;
        if (!rst_i) begin
            m_time = 64'd0; m_cmp = '1; m_msip = 1'b0; m_presc = 0; m_mtip = 1'b0;
            m_ack = 1'b0; m_err = 1'b0; m_dat = 32'd0; m_dat_chk = 1'b1;
            return;
        end
        req = cyc && stb && !m_ack && !m_err;
        nt = m_time; nc = m_cmp; twr = 1'b0;
        m_presc = (m_presc + 1) % TICK;
        tick = (m_presc == 0);
        m_mtip = (m_time >= m_cmp);
        m_ack = 1'b0; m_err = 1'b0; m_dat = 32'd0; m_dat_chk = 1'b0;
        if (req) begin
            r = decode(addr);
            m_dat_chk = 1'b1;
            if (r < 0) begin
                m_err = 1'b1;
            end else begin
                m_ack = 1'b1;
                if (!we) begin
                    m_dat_chk = 1'b1;
                    case (r)
                        0: m_dat = {31'd0, m_msip};
                        1: m_dat = m_cmp[31:0];
                        2: m_dat = m_cmp[63:32];
                        3: m_dat = m_time[31:0];
                        default: m_dat = m_time[63:32];
                    endcase
                end else begin
                    m_dat_chk = 1'b0;
                    case (r)
                        0: if (sel[0]) m_msip = wdat[0];
                        1: nc[31:0]  = merge(m_cmp[31:0], wdat, sel);
                        2: nc[63:32] = merge(m_cmp[63:32], wdat, sel);
                        3: begin nt[31:0]  = merge(m_time[31:0], wdat, sel);  twr = (sel != 0); end
                        default: begin nt[63:32] = merge(m_time[63:32], wdat, sel); twr = (sel != 0); end
                    endcase
                end
            end
        end
        if (!twr && tick) nt = m_time + 64'd1;
        m_time = nt;
        m_cmp  = nc;
    endtask

    // Single compare point: one clock edge, model update, then check outputs.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        chk("ack", ack_o, m_ack);
        chk("err", err_o, m_err);
        chk("mtip", mtip_o, m_mtip);
        chk("msip", msip_o, m_msip);
        if (m_dat_chk) chk("dat", dat_o, m_dat);
    endtask

    task automatic drive(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
        addr = a; we = w; wdat = d; sel = s; cyc = 1'b1; stb = 1'b1;
    endtask

    task automatic go_idle();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] rd, output logic ak, output logic er);
        drive(a, w, d, s);
        step();
        rd = dat_o; ak = ack_o; er = err_o;
        go_idle();
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        ak, er;
        int          r, hold;
        logic [31:0] a;

        repeat (3) step();
        chk("rst_ack", ack_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_dat", dat_o, 0);
        chk("rst_mtip", mtip_o, 0);
        chk("rst_msip", msip_o, 0);

        rst_i = 1'b1;
        repeat (10) step();
        bus(BASE + 32'hBFF8, 1'b0, 32'd0, 4'hF, rd, ak, er);
        chk("idle_mtime_lo", rd, 10);
        chk("idle_ack", ak, 1);
        bus(BASE + 32'hBFFC, 1'b0, 32'd0, 4'hF, rd, ak, er);
        chk("idle_mtime_hi", rd, 0);

        bus(BASE + 32'h4004, 1'b1, 32'd0, 4'hF, rd, ak, er);
        bus(BASE + 32'h4000, 1'b1, 32'd50, 4'hF, rd, ak, er);
        for (int i = 0; i < 200 && m_time != 64'd50; i++) step();
        chk("mtip_at_50", mtip_o, 0);
        step();
        chk("mtip_rise", mtip_o, 1);
        drive(BASE + 32'h4004, 1'b1, 32'd1, 4'hF);
        step();
        chk("mtip_hold", mtip_o, 1);
        go_idle();
        step();
        chk("mtip_fall", mtip_o, 0);

        drive(BASE, 1'b1, 32'd1, 4'hF);
        step();
        chk("msip_set", msip_o, 1);
        go_idle();
        step();
        bus(BASE, 1'b0, 32'd0, 4'hF, rd, ak, er);
        chk("msip_read", rd, 32'h0000_0001);
        bus(32'h0301_0000, 1'b1, 32'd0, 4'hF, rd, ak, er);
        chk("badbase_err", er, 1);
        chk("badbase_ack", ak, 0);
        chk("badbase_msip", msip_o, 1);
        bus(BASE, 1'b1, 32'hFFFF_FFFE, 4'hF, rd, ak, er);
        chk("msip_clr", msip_o, 0);

        bus(BASE + 32'h0010, 1'b0, 32'd0, 4'hF, rd, ak, er);
        chk("badoff_err", er, 1);
        chk("badoff_ack", ak, 0);
        chk("badoff_dat", rd, 0);

        bus(BASE + 32'hBFF8, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, ak, er);
        bus(BASE + 32'hBFFC, 1'b0, 32'd0, 4'hF, rd, ak, er);
        chk("wrap_hi", rd, 1);
        bus(BASE + 32'hBFFC, 1'b1, 32'h0000_1234, 4'b0001, rd, ak, er);
        bus(BASE + 32'hBFF8, 1'b0, 32'd0, 4'hF, rd, ak, er);
        chk("suppress_lo", rd, 3);
        bus(BASE + 32'hBFFC, 1'b0, 32'd0, 4'hF, rd, ak, er);
        chk("bytewr_hi", rd, 32'h34);

        drive(BASE + 32'hBFF8, 1'b0, 32'd0, 4'hF);
        for (int i = 0; i < 6; i++) begin
            chk("held_ack", ack_o, (i % 2 == 1) ? 1 : 0);
            step();
        end
        go_idle();
        step();

        bus(BASE, 1'b1, 32'd1, 4'hF, rd, ak, er);
        drive(BASE + 32'hBFF8, 1'b0, 32'd0, 4'hF);
        rst_i = 1'b0;
        step();
        chk("rstmid_ack", ack_o, 0);
        chk("rstmid_msip", msip_o, 0);
        go_idle();
        rst_i = 1'b1;
        step();
        bus(BASE + 32'h4000, 1'b0, 32'd0, 4'hF, rd, ak, er);
        chk("rstmid_cmp_lo", rd, 32'hFFFF_FFFF);
        bus(BASE + 32'h4004, 1'b0, 32'd0, 4'hF, rd, ak, er);
        chk("rstmid_cmp_hi", rd, 32'hFFFF_FFFF);
        bus(BASE + 32'hBFFC, 1'b0, 32'd0, 4'hF, rd, ak, er);
        chk("rstmid_time_hi", rd, 0);

        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 6);
            case (r)
                0: a = BASE;
                1: a = BASE + 32'h4000;
                2: a = BASE + 32'h4004;
                3: a = BASE + 32'hBFF8;
                4: a = BASE + 32'hBFFC;
                5: a = BASE + {16'd0, 16'($urandom)};
                default: a = {16'($urandom), 16'hBFF8};
            endcase
            a[1:0] = 2'($urandom);
            drive(a, 1'($urandom), $urandom, 4'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                if (r == 1) wdat = m_time[31:0] + $urandom_range(0, 12);
                if (r == 2) wdat = m_time[63:32];
            end
            if ((r == 3 || r == 4) && we && sel == 4'd0) sel = 4'hF;
            hold = $urandom_range(1, 3);
            for (int h = 0; h < hold; h++) step();
            go_idle();
            if ($urandom_range(0, 199) == 0) rst_i = 1'b0;
            for (int h = $urandom_range(0, 2); h >= 0; h--) begin
                step();
                rst_i = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mirfak_clint.md
Name: mirfak_clint

Overview:
- Wishbone classic slave core-local interruptor (timer + software interrupt) that drives the core's xint_mtip_i / xint_msip_i inputs, which are tied to 0 in the bare testbench.
- Holds 64-bit mtime, 64-bit mtimecmp and a 1-bit msip register, all memory-mapped.
- Sits on the data bus beside the RAM, behind the testbench address decoder.

Parameters:
- BASE_ADDR, 32'h0200_0000, base of the 64 KB register window; bits [31:16] must match.
- TICK_DIV, 1, clk_i cycles per mtime increment; legal range 1..65535.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-low reset
- wbs_addr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_sel_i  in  4  byte lane enables
- wbs_cyc_i  in  1  bus cycle
- wbs_stb_i  in  1  strobe
- wbs_we_i  in  1  write enable
- wbs_dat_o  out  32  read data
- wbs_ack_o  out  1  transfer acknowledge
- wbs_err_o  out  1  bus error for an unmapped offset
- xint_mtip_o  out  1  machine timer interrupt pending
- xint_msip_o  out  1  machine software interrupt pending

Behaviour:
- Reset (rst_i == 0 at a clk_i edge):
  - mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, msip = 0, prescaler = 0.
  - All outputs = 0, including wbs_dat_o.
- Register map (offset = wbs_addr_i[15:0]; bits [1:0] ignored):
  - 0x0000: MSIP. Bit 0 is R/W; bits 31:1 read 0.
  - 0x4000: MTIMECMP[31:0].
  - 0x4004: MTIMECMP[63:32].
  - 0xBFF8: MTIME[31:0].
  - 0xBFFC: MTIME[63:32].
  - Any other offset, or wbs_addr_i[31:16] != BASE_ADDR[31:16]: request is accepted, answered with wbs_err_o, no side effect, wbs_dat_o = 0.
- Handshake:
  - A request is cyc & stb & ~ack & ~err.
  - The request edge registers the response: exactly one of ack/err pulses high for one cycle, in the cycle after stb is first seen.
  - Fixed latency of 1. No back-to-back acks: a held stb yields ack every other cycle.
  - If cyc/stb drops while the response is outstanding, the response is still produced. Masters must ignore it. Side effects have already happened.
- Writes:
  - Applied at the request edge, byte-wise per wbs_sel_i. sel = 0 is a legal no-op that is still acked.
  - Reads return the value before any same-cycle increment.
- mtime:
  - Prescaler counts 0..TICK_DIV-1. mtime increments by 1 when the prescaler wraps. TICK_DIV = 1 means increment every cycle.
  - 64-bit wrap: FFFF_FFFF_FFFF_FFFF -> 0.
  - A bus write to either mtime half takes priority over the increment in that cycle. The written half takes the new bytes; the other half holds, with no carry.
  - The prescaler is not reset by mtime writes.
- Interrupts:
  - xint_mtip_o is registered: xint_mtip_o <= (mtime >= mtimecmp), using the current register values. Latency is 1 cycle after the state change.
  - Unsigned 64-bit comparison.
  - xint_msip_o = msip register, which updates 1 cycle after the write edge.
- Reset mid-transaction: any pending ack/err is dropped and registers return to reset values.

Decomposition:
- Package mirfak_clint_pkg:
  - Offset constants CLINT_MSIP, CLINT_MTIMECMP_LO/HI, CLINT_MTIME_LO/HI.
  - Reset value MTIMECMP_RST.
- Sub-module mirfak_clint_timer:
  - Contains the prescaler, the 64-bit mtime with byte-write/priority logic, the comparator and the mtip register.
  - The top level keeps the Wishbone decode, msip and response muxing.

Test Plan:
- Reset, then idle 10 cycles with TICK_DIV=1 -> read 0xBFF8 returns 10 ± bus latency (exact value per bench timing), 0xBFFC returns 0; mtip = 0; msip = 0.
- Write MTIMECMP_HI=0, MTIMECMP_LO=50 -> xint_mtip_o rises exactly 1 cycle after mtime reaches 50. Then write MTIMECMP_HI=1 -> mtip falls 1 cycle after the write edge.
- Write MSIP=1 -> xint_msip_o = 1 on the next cycle; reads return 0000_0001. Write 32'hFFFF_FFFE -> msip = 0.
- Write MTIME_LO=FFFF_FFFF with TICK_DIV=1 -> on the next ticks HI increments to 1, LO wraps to 0. Write MTIME_HI=1234 with sel=4'b0001 -> HI[7:0]=34 only; the increment is suppressed that cycle.
- Access offset 0x0010 and address 0x0301_0000 -> wbs_err_o pulses one cycle, no ack, dat_o = 0, no register changes.
- Hold stb high for 6 cycles on a read -> ack pattern 0,1,0,1,0,1. Assert rst_i=0 in the cycle between request and ack -> no ack; all registers return to reset values.
